// File: rtl/uart_msg_pkg.sv
// Shared message layout, word/timeout constants and FSM state type for the UART
// message assembler slice (constants carried over from uart_msg_consts.h).
package uart_msg_pkg;

    localparam int unsigned UART_MSG_WIDTH   = 32;
    localparam int unsigned UART_WORD_WIDTH  = 8;

    localparam int unsigned UART_HEADER_MSB  = 31;
    localparam int unsigned UART_HEADER_LSB  = 24;
    localparam int unsigned UART_PAYLOAD_MSB = 23;
    localparam int unsigned UART_PAYLOAD_LSB = 0;
    localparam int unsigned UART_HEADER_W    = UART_HEADER_MSB - UART_HEADER_LSB + 1;
    localparam int unsigned UART_PAYLOAD_W   = UART_PAYLOAD_MSB - UART_PAYLOAD_LSB + 1;

    typedef struct packed {
        logic [UART_HEADER_W-1:0]  header;
        logic [UART_PAYLOAD_W-1:0] payload;
    } uart_msg_t;

    localparam int unsigned WORDS_PER_MSG = UART_MSG_WIDTH / UART_WORD_WIDTH;

    // Two 10-bit UART frames (start + 8 data + stop) at BAUD, in clk cycles.
    localparam int unsigned CLK_RATE          = 12_000_000;
    localparam int unsigned BAUD              = 9600;
    localparam int unsigned UART_FRAME_BITS   = 10;
    localparam int unsigned UART_TIMEOUT_CLKS = 2 * UART_FRAME_BITS * CLK_RATE / BAUD;

    typedef enum logic {
        IDLE,
        ASSEMBLE
    } asm_state_t;

endpackage

// File: rtl/uart_msg_timeout_timer.sv
// Reloadable inter-word timer: counts cycles since the last reload while enabled
// and strobes expire when the count reaches TIMEOUT_CLKS-1.
module uart_msg_timeout_timer #(
    parameter int unsigned TIMEOUT_CLKS = 25000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic reload,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CLKS + 1);

    logic [CW-1:0] count;

    assign expire = enable && (count == CW'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (reload || !enable || expire) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_msg_assembler.sv
// Packs LSB-first UART words into one message with a valid/ready output register.
// Optional macro UART_MSG_ASM_DROP_CNT_EN adds a saturating drop_count output.
module uart_msg_assembler
    import uart_msg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = UART_WORD_WIDTH,
    parameter int unsigned MSG_WIDTH    = UART_MSG_WIDTH,
    parameter int unsigned TIMEOUT_CLKS = UART_TIMEOUT_CLKS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [MSG_WIDTH-1:0]  out_msg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
`ifdef UART_MSG_ASM_DROP_CNT_EN
    output logic [15:0]           drop_count,
`endif
    output logic                  overflow
);

    localparam int unsigned WORDS = MSG_WIDTH / DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(WORDS + 1);

    generate
        if ((MSG_WIDTH % DATA_WIDTH) != 0 || WORDS == 0) begin : g_bad_width
            $error("MSG_WIDTH must be a non-zero integer multiple of DATA_WIDTH");
        end
    endgenerate

    asm_state_t            state, state_next;
    logic [CNT_W-1:0]      count, count_next;
    logic [MSG_WIDTH-1:0]  asm_reg, asm_shift;
    logic                  expire;
    logic                  complete, timeout_drop, load_out, drop_full, consume;

    // New words enter at the top, so after WORDS shifts the first word sits at the LSBs.
    generate
        if (WORDS == 1) begin : g_single
            always_comb asm_shift = in_data;
        end else begin : g_multi
            always_comb asm_shift = {in_data, asm_reg[MSG_WIDTH-1:DATA_WIDTH]};
        end
    endgenerate

    uart_msg_timeout_timer #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (state == ASSEMBLE),
        .reload (in_valid),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (in_valid && !complete) state_next = ASSEMBLE;
            ASSEMBLE: if (complete || timeout_drop) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        complete     = in_valid && (count == CNT_W'(WORDS - 1));
        timeout_drop = (state == ASSEMBLE) && expire && !in_valid;
        consume      = out_valid && out_ready;
        load_out     = complete && (!out_valid || out_ready);
        drop_full    = complete && out_valid && !out_ready;
        count_next   = count;
        if (complete || timeout_drop) begin
            count_next = '0;
        end else if (in_valid) begin
            count_next = count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            busy      <= 1'b0;
            asm_reg   <= '0;
            out_msg   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            count    <= count_next;
            busy     <= (count_next != '0);
            overflow <= drop_full;
            if (timeout_drop || complete) begin
                asm_reg <= '0;
            end else if (in_valid) begin
                asm_reg <= asm_shift;
            end
            if (load_out) begin
                out_msg   <= asm_shift;
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef UART_MSG_ASM_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if ((drop_full || timeout_drop) && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_msg_assembler.sv
// Scoreboard bench for uart_msg_assembler (32-bit messages, 8-bit words, 100-cycle
// timeout); also checks drop_count when UART_MSG_ASM_DROP_CNT_EN is defined.
module tb_uart_msg_assembler;
    import uart_msg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic [31:0] out_msg;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        overflow;
`ifdef UART_MSG_ASM_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned ovf_seen = 0;
    logic [31:0] exp_q[$];

    uart_msg_assembler #(
        .DATA_WIDTH   (8),
        .MSG_WIDTH    (32),
        .TIMEOUT_CLKS (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_msg    (out_msg),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
`ifdef UART_MSG_ASM_DROP_CNT_EN
        .drop_count (drop_count),
`endif
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected message.
    always @(negedge clk) begin
        if (!rst && overflow) ovf_seen++;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {32'h0, out_msg}, 64'hDEAD_0000_0000);
            end else begin
                check("scoreboard_msg", {32'h0, out_msg}, {32'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_msg(input logic [31:0] m);
        for (int unsigned i = 0; i < 4; i++) begin
            logic [31:0] tmp;
            tmp = m >> (8 * i);
            send_byte(tmp[7:0]);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        uart_msg_t    m;
        int unsigned  k;

        // Reset state
        idle(3);
        check("reset_out_valid", {63'h0, out_valid}, 64'h0);
        check("reset_out_msg", {32'h0, out_msg}, 64'h0);
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_overflow", {63'h0, overflow}, 64'h0);
`ifdef UART_MSG_ASM_DROP_CNT_EN
        check("reset_drop_count", {48'h0, drop_count}, 64'h0);
`endif
        rst = 1'b0;
        idle(2);

        // Basic assembly, LSB first
        out_ready = 1'b1;
        exp_q.push_back(32'h4433_2211);
        send_byte(8'h11);
        check("busy_after_first", {63'h0, busy}, 64'h1);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        check("basic_valid", {63'h0, out_valid}, 64'h1);
        check("basic_msg", {32'h0, out_msg}, 64'h4433_2211);
        m = out_msg;
        check("basic_header", {56'h0, m.header}, 64'h44);
        check("basic_busy_clear", {63'h0, busy}, 64'h0);
        idle(1);
        check("basic_valid_clear", {63'h0, out_valid}, 64'h0);

        // Timeout resync
        send_byte(8'hAA);
        send_byte(8'hBB);
        k = 0;
        while (busy && k < 200) begin
            idle(1);
            k++;
        end
        check("timeout_busy_fall", 64'(k), 64'd100);
        idle(150 - k);
        check("timeout_no_output", {63'h0, out_valid}, 64'h0);
        exp_q.push_back(32'h0403_0201);
        send_msg(32'h0403_0201);
        check("timeout_resync_msg", {32'h0, out_msg}, 64'h0403_0201);
        check("timeout_no_overflow", 64'(ovf_seen), 64'd0);
`ifdef UART_MSG_ASM_DROP_CNT_EN
        check("timeout_drop_count", {48'h0, drop_count}, 64'd1);
`endif
        idle(2);

        // Back-pressure and overflow
        pulse_reset();
        out_ready = 1'b0;
        exp_q.push_back(32'h4433_2211);
        send_msg(32'h4433_2211);
        idle(3);
        send_msg(32'h8877_6655);
        check("ovf_pulse", {63'h0, overflow}, 64'h1);
        check("ovf_held_msg", {32'h0, out_msg}, 64'h4433_2211);
        idle(1);
        check("ovf_single_pulse", {63'h0, overflow}, 64'h0);
        idle(3);
        check("ovf_still_valid", {63'h0, out_valid}, 64'h1);
        check("ovf_still_msg", {32'h0, out_msg}, 64'h4433_2211);
        out_ready = 1'b1;
        idle(1);
        check("ovf_accepted", {63'h0, out_valid}, 64'h0);
        check("ovf_count", 64'(ovf_seen), 64'd1);
`ifdef UART_MSG_ASM_DROP_CNT_EN
        check("ovf_drop_count", {48'h0, drop_count}, 64'd1);
`endif

        // Simultaneous accept and complete
        out_ready = 1'b0;
        exp_q.push_back(32'h4433_2211);
        exp_q.push_back(32'h8877_6655);
        send_msg(32'h4433_2211);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        in_data   = 8'h88;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("simul_valid", {63'h0, out_valid}, 64'h1);
        check("simul_msg", {32'h0, out_msg}, 64'h8877_6655);
        check("simul_no_overflow", {63'h0, overflow}, 64'h0);
        out_ready = 1'b1;
        idle(1);
        check("simul_drained", {63'h0, out_valid}, 64'h0);
        check("simul_ovf_count", 64'(ovf_seen), 64'd1);

        // Reset mid-message
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_reset();
        check("midrst_busy", {63'h0, busy}, 64'h0);
        check("midrst_valid", {63'h0, out_valid}, 64'h0);
        exp_q.push_back(32'h0403_0201);
        send_msg(32'h0403_0201);
        check("midrst_msg", {32'h0, out_msg}, 64'h0403_0201);
        idle(3);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
